// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between the instruction-fetch and data requesters.
// One transaction is in flight at a time: grant in IDLE, address phase, then data phase.
module sram_port_arbiter #(
   parameter int unsigned DATA_FIRST = 1
) (
   input  logic        clk,
   input  logic        reset,
   // instruction requester
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // data requester
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // shared port
   output logic        sram_req,
   output logic        sram_wr,
   output logic [1:0]  sram_size,
   output logic [3:0]  sram_wstrb,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic        sram_addr_ok,
   input  logic        sram_data_ok,
   input  logic [31:0] sram_rdata
);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e      state_q;
   logic        own_q;       // 0: inst, 1: data
   logic        last_own_q;  // owner of the last completed transaction
   logic        sram_req_q;
   logic        sram_wr_q;
   logic [1:0]  sram_size_q;
   logic [3:0]  sram_wstrb_q;
   logic [31:0] sram_addr_q;
   logic [31:0] sram_wdata_q;
   logic        grant_data_d;
   logic        addr_hit;
   logic        data_hit;

   // Arbitration: lone requester wins; on a tie either data wins outright or the
   // requester that did not own the previous transaction wins.
   always_comb begin
      grant_data_d = 1'b0;
      if (data_req && !inst_req) begin
         grant_data_d = 1'b1;
      end else if (data_req && inst_req) begin
         grant_data_d = (DATA_FIRST != 0) ? 1'b1 : !last_own_q;
      end
   end

   // Transaction sequencer with latched request fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         own_q        <= 1'b0;
         last_own_q   <= 1'b1;
         sram_req_q   <= 1'b0;
         sram_wr_q    <= 1'b0;
         sram_size_q  <= 2'd0;
         sram_wstrb_q <= 4'd0;
         sram_addr_q  <= 32'd0;
         sram_wdata_q <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (inst_req || data_req) begin
                  own_q      <= grant_data_d;
                  sram_req_q <= 1'b1;
                  state_q    <= StAddr;
                  if (grant_data_d) begin
                     sram_wr_q    <= data_wr;
                     sram_size_q  <= data_size;
                     sram_wstrb_q <= data_wstrb;
                     sram_addr_q  <= data_addr;
                     sram_wdata_q <= data_wdata;
                  end else begin
                     sram_wr_q    <= 1'b0;
                     sram_size_q  <= 2'd2;
                     sram_wstrb_q <= 4'd0;
                     sram_addr_q  <= inst_addr;
                     sram_wdata_q <= 32'd0;
                  end
               end
            end
            StAddr: begin
               if (sram_addr_ok) begin
                  sram_req_q <= 1'b0;
                  state_q    <= StData;
               end
            end
            StData: begin
               if (sram_data_ok) begin
                  last_own_q <= own_q;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Handshake pulses are routed to the owner only, in the matching phase.
   always_comb begin
      addr_hit     = (state_q == StAddr) && sram_addr_ok;
      data_hit     = (state_q == StData) && sram_data_ok;
      inst_addr_ok = addr_hit && !own_q;
      data_addr_ok = addr_hit && own_q;
      inst_data_ok = data_hit && !own_q;
      data_data_ok = data_hit && own_q;
      inst_rdata   = inst_data_ok ? sram_rdata : 32'd0;
      data_rdata   = data_data_ok ? sram_rdata : 32'd0;
   end

   assign sram_req   = sram_req_q;
   assign sram_wr    = sram_wr_q;
   assign sram_size  = sram_size_q;
   assign sram_wstrb = sram_wstrb_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (DATA_FIRST=0 and 1) share all inputs;
// a scoreboard per instance holds the expected owner and read data of each response.
module tb_sram_port_arbiter;

   typedef struct packed {
      logic        own;
      logic [31:0] rdata;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        sram_addr_ok;
   logic        sram_data_ok;
   logic [31:0] sram_rdata;

   // index 0: DATA_FIRST=0, index 1: DATA_FIRST=1
   logic        inst_addr_ok_w [2];
   logic        inst_data_ok_w [2];
   logic [31:0] inst_rdata_w   [2];
   logic        data_addr_ok_w [2];
   logic        data_data_ok_w [2];
   logic [31:0] data_rdata_w   [2];
   logic        sram_req_w     [2];
   logic        sram_wr_w      [2];
   logic [1:0]  sram_size_w    [2];
   logic [3:0]  sram_wstrb_w   [2];
   logic [31:0] sram_addr_w    [2];
   logic [31:0] sram_wdata_w   [2];

   int    n_checks = 0;
   int    n_errors = 0;
   bit    mon_en   = 1'b0;
   resp_t q0[$];
   resp_t q1[$];

   always #5 clk = ~clk;

   sram_port_arbiter #(.DATA_FIRST(0)) dut0 (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok_w[0]), .inst_data_ok(inst_data_ok_w[0]),
      .inst_rdata(inst_rdata_w[0]),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok_w[0]), .data_data_ok(data_data_ok_w[0]),
      .data_rdata(data_rdata_w[0]),
      .sram_req(sram_req_w[0]), .sram_wr(sram_wr_w[0]), .sram_size(sram_size_w[0]),
      .sram_wstrb(sram_wstrb_w[0]), .sram_addr(sram_addr_w[0]), .sram_wdata(sram_wdata_w[0]),
      .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
   );

   sram_port_arbiter #(.DATA_FIRST(1)) dut1 (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok_w[1]), .inst_data_ok(inst_data_ok_w[1]),
      .inst_rdata(inst_rdata_w[1]),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok_w[1]), .data_data_ok(data_data_ok_w[1]),
      .data_rdata(data_rdata_w[1]),
      .sram_req(sram_req_w[1]), .sram_wr(sram_wr_w[1]), .sram_size(sram_size_w[1]),
      .sram_wstrb(sram_wstrb_w[1]), .sram_addr(sram_addr_w[1]), .sram_wdata(sram_wdata_w[1]),
      .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
   );

   task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected latched fields {wr,size,wstrb,addr,wdata} for a given owner.
   function automatic logic [70:0] exp_fields(input logic own);
      if (own) return {data_wr, data_size, data_wstrb, data_addr, data_wdata};
      return {1'b0, 2'd2, 4'd0, inst_addr, 32'd0};
   endfunction

   function automatic logic [70:0] got_fields(input int i);
      return {sram_wr_w[i], sram_size_w[i], sram_wstrb_w[i], sram_addr_w[i], sram_wdata_w[i]};
   endfunction

   // Response monitor: pops the scoreboard on every data_ok pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            if (inst_data_ok_w[i] === 1'b1 || data_data_ok_w[i] === 1'b1) begin
               resp_t e;
               int    sz;
               sz = (i == 0) ? q0.size() : q1.size();
               if (sz == 0) begin
                  check_eq($sformatf("unexpected_data_ok%0d", i), 1, 0);
               end else begin
                  e = (i == 0) ? q0.pop_front() : q1.pop_front();
                  check_eq($sformatf("resp_owner%0d", i),
                           {70'd0, inst_data_ok_w[i], data_data_ok_w[i]},
                           {70'd0, !e.own, e.own});
                  check_eq($sformatf("resp_rdata%0d", i),
                           {inst_rdata_w[i], data_rdata_w[i]},
                           e.own ? {32'd0, e.rdata} : {e.rdata, 32'd0});
               end
            end else begin
               check_eq($sformatf("idle_rdata%0d", i), {inst_rdata_w[i], data_rdata_w[i]}, 0);
            end
         end
      end
   end

   task automatic apply_reset();
      reset        = 1'b1;
      inst_req     = 1'b0;
      data_req     = 1'b0;
      sram_addr_ok = 1'b0;
      sram_data_ok = 1'b0;
      tick();
      tick();
      mon_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("rst_req%0d", i), {71'd0, sram_req_w[i]}, 0);
         check_eq($sformatf("rst_fields%0d", i), {1'b0, got_fields(i)}, 0);
         check_eq($sformatf("rst_pulses%0d", i),
                  {inst_addr_ok_w[i], inst_data_ok_w[i], data_addr_ok_w[i], data_data_ok_w[i]}, 0);
      end
      reset = 1'b0;
   endtask

   // One full transaction, starting in IDLE with requests already driven.
   task automatic do_txn(input logic own0, input logic own1, input logic [31:0] rdata,
                         input int addr_wait, input int data_wait,
                         input bit clr_inst, input bit clr_data);
      logic [70:0] ef [2];
      logic        own [2];
      own[0] = own0;
      own[1] = own1;
      for (int i = 0; i < 2; i++) ef[i] = exp_fields(own[i]);
      q0.push_back('{own: own0, rdata: rdata});
      q1.push_back('{own: own1, rdata: rdata});
      tick();
      for (int w = 0; w <= addr_wait; w++) begin
         if (w == 1) data_addr = data_addr + 32'h40;  // must not disturb latched fields
         for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("addr_req%0d", i), {71'd0, sram_req_w[i]}, 1);
            check_eq($sformatf("addr_fields%0d", i), {1'b0, got_fields(i)}, {1'b0, ef[i]});
            if (w < addr_wait)
               check_eq($sformatf("early_addr_ok%0d", i),
                        {70'd0, inst_addr_ok_w[i], data_addr_ok_w[i]}, 0);
         end
         if (w < addr_wait) tick();
      end
      sram_addr_ok = 1'b1;
      #1;
      for (int i = 0; i < 2; i++)
         check_eq($sformatf("addr_ok%0d", i), {70'd0, inst_addr_ok_w[i], data_addr_ok_w[i]},
                  {70'd0, !own[i], own[i]});
      tick();
      sram_addr_ok = 1'b0;
      if (clr_inst) inst_req = 1'b0;
      if (clr_data) data_req = 1'b0;
      for (int i = 0; i < 2; i++)
         check_eq($sformatf("data_req_low%0d", i), {71'd0, sram_req_w[i]}, 0);
      for (int w = 0; w < data_wait; w++) tick();
      sram_rdata   = rdata;
      sram_data_ok = 1'b1;
      tick();
      sram_data_ok = 1'b0;
      sram_rdata   = $urandom;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      inst_addr  = 32'd0;
      data_wr    = 1'b0;
      data_size  = 2'd2;
      data_wstrb = 4'd0;
      data_addr  = 32'd0;
      data_wdata = 32'd0;
      sram_rdata = 32'd0;
      apply_reset();

      // inst only
      inst_req  = 1'b1;
      inst_addr = 32'hBFC0_0000;
      do_txn(1'b0, 1'b0, 32'h2401_0001, 0, 2, 1'b1, 1'b0);

      // simultaneous: both instances pick data first (dut0 because inst owned last)
      inst_req  = 1'b1;
      inst_addr = 32'hBFC0_0004;
      data_req  = 1'b1;
      data_addr = 32'h0000_1000;
      do_txn(1'b1, 1'b1, 32'hDEAD_BEEF, 0, 1, 1'b0, 1'b1);
      do_txn(1'b0, 1'b0, 32'h1234_5678, 0, 0, 1'b1, 1'b0);

      // round-robin from reset with both held
      apply_reset();
      inst_req  = 1'b1;
      inst_addr = 32'hBFC0_0010;
      data_req  = 1'b1;
      data_addr = 32'h0000_2000;
      do_txn(1'b0, 1'b1, 32'h0000_0011, 0, 0, 1'b0, 1'b0);
      do_txn(1'b1, 1'b1, 32'h0000_0022, 0, 1, 1'b0, 1'b0);
      do_txn(1'b0, 1'b1, 32'h0000_0033, 0, 0, 1'b1, 1'b1);

      // byte store
      data_req   = 1'b1;
      data_wr    = 1'b1;
      data_size  = 2'd0;
      data_wstrb = 4'b0100;
      data_addr  = 32'h0000_1002;
      data_wdata = 32'h00AB_0000;
      do_txn(1'b1, 1'b1, 32'h0000_0000, 0, 0, 1'b0, 1'b1);
      data_wr    = 1'b0;
      data_size  = 2'd2;
      data_wstrb = 4'd0;

      // address phase stalled 5 cycles while requester changes its address
      data_req  = 1'b1;
      data_addr = 32'h0000_3000;
      do_txn(1'b1, 1'b1, 32'hCAFE_F00D, 5, 0, 1'b0, 1'b1);

      // reset during the data phase, then a late data_ok
      data_req  = 1'b1;
      data_addr = 32'h0000_4000;
      tick();
      data_req     = 1'b0;
      sram_addr_ok = 1'b1;
      tick();
      sram_addr_ok = 1'b0;
      reset        = 1'b1;
      tick();
      reset        = 1'b0;
      sram_rdata   = 32'h5555_AAAA;
      sram_data_ok = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("late_data_ok%0d", i),
                  {70'd0, inst_data_ok_w[i], data_data_ok_w[i]}, 0);
         check_eq($sformatf("late_req%0d", i), {71'd0, sram_req_w[i]}, 0);
      end
      tick();
      sram_data_ok = 1'b0;
      tick();
      for (int i = 0; i < 2; i++)
         check_eq($sformatf("post_rst_idle%0d", i), {71'd0, sram_req_w[i]}, 0);

      check_eq("sb_left0", q0.size(), 0);
      check_eq("sb_left1", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
